// File: rtl/soc_test_monitor.sv
// End-of-test checker for cpu6 directed tests: shadows the register file from the
// writeback port and, once the pc reaches end_pc, compares selected registers.
module soc_test_monitor #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NCHK    = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 smp_en,
  input  logic [XLEN-1:0]      pc,
  input  logic                 rf_we,
  input  logic [4:0]           rf_waddr,
  input  logic [XLEN-1:0]      rf_wdata,
  input  logic [XLEN-1:0]      end_pc,
  input  logic [NCHK-1:0]      chk_en,
  input  logic [NCHK*5-1:0]    chk_idx,
  input  logic [NCHK*XLEN-1:0] chk_val,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [NCHK-1:0]      fail_mask,
  output logic [CNT_W-1:0]     cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  // Timeout counter is sized for TIMEOUT-1 independently of the exported cycle_cnt.
  localparam int              RUN_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [XLEN-1:0]  shadow [NREG];
  logic             active, hit_end, hit_timeout;
  logic             cnt_inc, verdict_ld, timeout_ld;
  logic [NCHK-1:0]  mismatch;

  // IDLE and RUN treat an enabled sample identically; IDLE just has not seen one yet.
  assign active      = smp_en && ((state == S_IDLE) || (state == S_RUN));
  assign hit_end     = active && (pc == end_pc);
  assign hit_timeout = active && !hit_end && (run_cnt == RUN_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RUN: begin
        if (hit_end)          state_nxt = S_CHECK;
        else if (hit_timeout) state_nxt = S_DONE;
        else if (active)      state_nxt = S_RUN;
      end
      S_CHECK: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_inc    = active && !hit_end && !hit_timeout;
    verdict_ld = (state == S_CHECK);
    timeout_ld = hit_timeout;
  end

  // NOTE: the shadow file is reset on purpose, since checks against never-written registers expect 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (active && rf_we && (rf_waddr != 5'd0) && (int'(rf_waddr) < NREG)) begin
      shadow[rf_waddr] <= rf_wdata;
    end
  end

  // Out-of-range indices count as mismatches rather than aliasing onto a real register.
  always_comb begin
    logic [4:0]      idx;
    logic [XLEN-1:0] val;
    mismatch = '0;
    idx      = '0;
    val      = '0;
    for (int k = 0; k < NCHK; k++) begin
      idx = chk_idx[5*k +: 5];
      val = chk_val[XLEN*k +: XLEN];
      if (chk_en[k]) begin
        if (int'(idx) >= NREG)      mismatch[k] = 1'b1;
        else if (shadow[idx] != val) mismatch[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt   <= '0;
      cycle_cnt <= '0;
    end else if (cnt_inc) begin
      run_cnt <= run_cnt + RUN_W'(1);
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_mask <= '0;
    end else if (verdict_ld) begin
      done      <= 1'b1;
      pass      <= ~|mismatch;
      fail      <= |mismatch;
      timeout   <= 1'b0;
      fail_mask <= mismatch;
    end else if (timeout_ld) begin
      done      <= 1'b1;
      pass      <= 1'b0;
      fail      <= 1'b1;
      timeout   <= 1'b1;
      fail_mask <= '0;
    end
  end

endmodule
